regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised successor to the single-read-port register bank: NRD combinational read ports, one
//  ALU writeback port and one memory-load return port. A per-register pending-write scoreboard lets
//  the control FSM issue a RAM load, keep executing, and stall only when an instruction reads a
//  register whose load has not returned. Sits between decoder, ALU operand muxes and data-RAM return.
// PARAMETERS
//  XLEN   32  data width of each register
//  NREGS  32  number of architectural registers; power of two, >=2; x0 hardwired to zero
//  NRD    2   number of read ports (rs1, rs2, ...)
//  AW     $clog2(NREGS)  register address width (derived, do not override)
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous active-low reset
//  rd_addr     in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data     out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN], combinational + bypass
//  rd_busy     out  NRD       port i addresses a register with an unreturned load
//  wr_en       in   1         ALU writeback strobe
//  wr_addr     in   AW        ALU writeback destination
//  wr_data     in   XLEN      ALU writeback value
//  claim_en    in   1         load issued: mark claim_addr pending
//  claim_addr  in   AW        load destination register
//  ld_valid    in   1         load data returned from RAM
//  ld_addr     in   AW        destination of returned load
//  ld_data     in   XLEN      returned load value
//  pend_count  out  AW+1      number of registers currently pending
//  err         out  1         sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers <= 0, pending <= 0, pend_count <= 0, err <= 0;
//   rd_data therefore reads 0, rd_busy reads 0. Reset mid-load discards the outstanding claim.
//  x0: reads always 0, never busy; wr/claim/ld targeting x0 are ignored and never set err.
//  Writes: register updates on rising clk. wr and ld to different addresses both commit same cycle.
//   wr and ld to the same address in the same cycle: ld_data commits, err <= 1.
//  Read (zero-latency, combinational): for each port, priority
//   1) addr==0 -> 0; 2) ld_valid & ld_addr==addr -> ld_data; 3) wr_en & wr_addr==addr -> wr_data;
//   4) stored register value.
//  rd_busy[i] = pending[addr_i] & ~(ld_valid & ld_addr==addr_i); addr 0 -> 0.
//  Scoreboard, per register r!=0, next state:
//   claim_en & claim_addr==r            -> pending <= 1 (claim wins over same-cycle ld to r)
//   else ld_valid & ld_addr==r          -> pending <= 0
//   else                                -> hold
//  pend_count = population of pending after update; registered, equals popcount(pending) always.
//   Range 0..NREGS-1; cannot wrap since x0 is never pending.
//  err set (sticky until reset) on any of:
//   claim to an already-pending register not returning this cycle (WAW on load);
//   wr_en to a pending register not returning this cycle (write still commits, pending held);
//   ld_valid to a non-pending register (write still commits);
//   wr/ld same-address collision (above).
//  No handshake back-pressure: the control FSM must stall on rd_busy; block never blocks inputs.
// TESTING
//  1 Reset then write x5=0xDEADBEEF, read rs1=x5 next cycle -> 0xDEADBEEF; read x0 after wr x0=1 -> 0.
//  2 wr_en x7=0x12 and rd_addr port1=x7 same cycle -> rd_data1=0x12 (bypass), stored value next cycle.
//  3 claim x3; next cycle read x3 -> rd_busy=1, pend_count=1; ld_valid x3=0xA5 -> same cycle
//    rd_busy=0, rd_data=0xA5; following cycle pend_count=0, err=0.
//  4 claim x1,x2,x4 over 3 cycles -> pend_count 1,2,3; return x2 with claim x6 same cycle -> stays 3.
//  5 ld_valid x9 with no claim -> x9 written, err=1; err stays 1 until rst_n pulse, then 0.
//  6 claim x8, assert rst_n=0 asynchronously mid-cycle -> pending, pend_count, x8 all 0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Register-bank bus: read ports, ALU writeback, load claim/return, scoreboard status.
interface regfile_scoreboard_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                claim_en;
    logic [AW-1:0]       claim_addr;
    logic                ld_valid;
    logic [AW-1:0]       ld_addr;
    logic [XLEN-1:0]     ld_data;
    logic [AW:0]         pend_count;
    logic                err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
               ld_valid, ld_addr, ld_data,
        input  rd_data, rd_busy, pend_count, err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
               ld_valid, ld_addr, ld_data,
        output rd_data, rd_busy, pend_count, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with pending-load scoreboard and zero-latency bypassed reads.
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_scoreboard_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic [AW:0]      pend_count_q, pend_count_d;
    logic             err_q, err_d;

    logic wr_act_c, ld_act_c, claim_act_c;
    logic claim_viol_c, wr_viol_c, ld_viol_c, coll_c;

    assign wr_act_c    = bus.wr_en    && (bus.wr_addr    != '0);
    assign ld_act_c    = bus.ld_valid && (bus.ld_addr    != '0);
    assign claim_act_c = bus.claim_en && (bus.claim_addr != '0);

    // Protocol violations, evaluated against the pre-update scoreboard
    always_comb begin
        claim_viol_c = claim_act_c && pending_q[bus.claim_addr]
                       && !(ld_act_c && (bus.ld_addr == bus.claim_addr));
        wr_viol_c    = wr_act_c && pending_q[bus.wr_addr]
                       && !(ld_act_c && (bus.ld_addr == bus.wr_addr));
        ld_viol_c    = ld_act_c && !pending_q[bus.ld_addr];
        coll_c       = wr_act_c && ld_act_c && (bus.wr_addr == bus.ld_addr);
    end

    // Next register contents, scoreboard, population count and sticky error
    always_comb begin
        regs_d       = regs_q;
        pending_d    = pending_q;
        pend_count_d = '0;
        err_d        = err_q | claim_viol_c | wr_viol_c | ld_viol_c | coll_c;

        if (wr_act_c) regs_d[bus.wr_addr] = bus.wr_data;
        if (ld_act_c) regs_d[bus.ld_addr] = bus.ld_data;   // load wins a collision
        regs_d[0] = '0;

        for (int unsigned r = 1; r < NREGS; r++) begin
            if (claim_act_c && (bus.claim_addr == AW'(r))) begin
                pending_d[r] = 1'b1;
            end else if (ld_act_c && (bus.ld_addr == AW'(r))) begin
                pending_d[r] = 1'b0;
            end
        end
        pending_d[0] = 1'b0;

        for (int unsigned r = 0; r < NREGS; r++) begin
            pend_count_d = pend_count_d + (AW+1)'(pending_d[r]);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
            pending_q    <= '0;
            pend_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            pending_q    <= pending_d;
            pend_count_q <= pend_count_d;
            err_q        <= err_d;
        end
    end

    assign bus.pend_count = pend_count_q;
    assign bus.err        = err_q;

    // Per-port read mux: x0, then returning load, then ALU writeback, then storage
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] addr_c;
        logic          ld_hit_c, wr_hit_c;

        assign addr_c   = bus.rd_addr[gi*AW +: AW];
        assign ld_hit_c = bus.ld_valid && (bus.ld_addr == addr_c);
        assign wr_hit_c = bus.wr_en    && (bus.wr_addr == addr_c);

        assign bus.rd_data[gi*XLEN +: XLEN] = (addr_c == '0) ? '0          :
                                              ld_hit_c       ? bus.ld_data :
                                              wr_hit_c       ? bus.wr_data :
                                                               regs_q[addr_c];
        assign bus.rd_busy[gi] = (addr_c != '0) && pending_q[addr_c] && !ld_hit_c;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vectors plus randomized traffic checked against a set-based reference model.
module tb_regfile_scoreboard;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        claim_en;
        logic [4:0]  claim_addr;
        logic        ld_valid;
        logic [4:0]  ld_addr;
        logic [31:0] ld_data;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [1:0]  exp_busy;
        logic [5:0]  exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    // Reference model: register values plus a set of pending registers
    logic [31:0] m_mem [32];
    bit          m_pend [int];
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ce, input logic [4:0] ca,
                         input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                         input logic [4:0] r0, input logic [4:0] r1);
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.claim_en = ce; bus.claim_addr = ca;
        bus.ld_valid = lv; bus.ld_addr = la; bus.ld_data = ldd;
        bus.rd_addr = {r1, r0};
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_mem[r] = '0;
        m_pend.delete();
        m_err = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (bus.ld_valid && int'(bus.ld_addr) == a) return bus.ld_data;
        if (bus.wr_en && int'(bus.wr_addr) == a) return bus.wr_data;
        return m_mem[a];
    endfunction

    function automatic bit m_busy(input int a);
        if (a == 0) return 0;
        return m_pend.exists(a) && !(bus.ld_valid && int'(bus.ld_addr) == a);
    endfunction

    // Compare all outputs against the model, then advance the model by one clock
    task automatic model_check_and_step();
        int wa, ca, la;
        bit we, ce, lv;
        for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(bus.rd_addr[p*AW +: AW]);
            chk($sformatf("rnd_rd_data%0d", p), 64'(bus.rd_data[p*XLEN +: XLEN]), 64'(m_read(a)));
            chk($sformatf("rnd_rd_busy%0d", p), 64'(bus.rd_busy[p]), 64'(m_busy(a)));
        end
        chk("rnd_pend_count", 64'(bus.pend_count), 64'(m_pend.num()));
        chk("rnd_err", 64'(bus.err), 64'(m_err));

        wa = int'(bus.wr_addr); ca = int'(bus.claim_addr); la = int'(bus.ld_addr);
        we = bus.wr_en && wa != 0; ce = bus.claim_en && ca != 0; lv = bus.ld_valid && la != 0;
        if (ce && m_pend.exists(ca) && !(lv && la == ca)) m_err = 1;
        if (we && m_pend.exists(wa) && !(lv && la == wa)) m_err = 1;
        if (lv && !m_pend.exists(la)) m_err = 1;
        if (we && lv && wa == la) m_err = 1;
        if (we) m_mem[wa] = bus.wr_data;
        if (lv) m_mem[la] = bus.ld_data;
        if (ce) m_pend[ca] = 1;
        if (lv && !(ce && ca == la)) m_pend.delete(la);
    endtask

    initial begin
        // in: we wa wd ce ca lv la ld rd0 rd1 | exp rd0 rd1 busy pc err
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,   0, 0, 0,          0,     2'b00, 0, 0};
        vecs[1]  = '{1, 0, 32'h1,        0, 0, 0, 0, 0,   5, 0, 32'hDEADBEEF, 0,   2'b00, 0, 0};
        vecs[2]  = '{1, 7, 32'h12,       0, 0, 0, 0, 0,   0, 7, 0,          32'h12, 2'b00, 0, 0};
        vecs[3]  = '{0, 0, 0,            1, 3, 0, 0, 0,   7, 0, 32'h12,     0,     2'b00, 0, 0};
        vecs[4]  = '{0, 0, 0,            0, 0, 0, 0, 0,   3, 7, 0,          32'h12, 2'b01, 1, 0};
        vecs[5]  = '{0, 0, 0,            0, 0, 1, 3, 32'hA5, 3, 5, 32'hA5,  32'hDEADBEEF, 2'b00, 1, 0};
        vecs[6]  = '{0, 0, 0,            0, 0, 0, 0, 0,   3, 0, 32'hA5,     0,     2'b00, 0, 0};
        vecs[7]  = '{0, 0, 0,            1, 1, 0, 0, 0,   0, 0, 0,          0,     2'b00, 0, 0};
        vecs[8]  = '{0, 0, 0,            1, 2, 0, 0, 0,   1, 0, 0,          0,     2'b01, 1, 0};
        vecs[9]  = '{0, 0, 0,            1, 4, 0, 0, 0,   2, 1, 0,          0,     2'b11, 2, 0};
        vecs[10] = '{0, 0, 0,            1, 6, 1, 2, 32'h22, 2, 4, 32'h22,  0,     2'b10, 3, 0};
        vecs[11] = '{0, 0, 0,            0, 0, 0, 0, 0,   6, 2, 0,          32'h22, 2'b01, 3, 0};
        vecs[12] = '{0, 0, 0,            0, 0, 1, 9, 32'h99, 9, 0, 32'h99,  0,     2'b00, 3, 0};
        vecs[13] = '{0, 0, 0,            0, 0, 0, 0, 0,   9, 1, 32'h99,     0,     2'b10, 3, 1};

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 3);
        #3;
        chk("reset_pend_count", 64'(bus.pend_count), 0);
        chk("reset_err", 64'(bus.err), 0);
        chk("reset_rd_data", 64'(bus.rd_data), 0);
        chk("reset_rd_busy", 64'(bus.rd_busy), 0);
        do_reset();

        // Directed table
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].wr_en, vecs[v].wr_addr, vecs[v].wr_data, vecs[v].claim_en,
                  vecs[v].claim_addr, vecs[v].ld_valid, vecs[v].ld_addr, vecs[v].ld_data,
                  vecs[v].rd0, vecs[v].rd1);
            @(negedge clk);
            chk($sformatf("vec%0d_rd0", v), 64'(bus.rd_data[31:0]), 64'(vecs[v].exp_rd0));
            chk($sformatf("vec%0d_rd1", v), 64'(bus.rd_data[63:32]), 64'(vecs[v].exp_rd1));
            chk($sformatf("vec%0d_busy", v), 64'(bus.rd_busy), 64'(vecs[v].exp_busy));
            chk($sformatf("vec%0d_pc", v), 64'(bus.pend_count), 64'(vecs[v].exp_pc));
            chk($sformatf("vec%0d_err", v), 64'(bus.err), 64'(vecs[v].exp_err));
            @(posedge clk); #1;
        end

        // Sticky err survives idle cycles, clears on reset
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 64'(bus.err), 1);
        do_reset();
        chk("err_cleared", 64'(bus.err), 0);
        chk("pc_cleared", 64'(bus.pend_count), 0);

        // Asynchronous reset mid-load discards claim and data
        drive(1, 8, 32'h55, 0, 0, 0, 0, 0, 8, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 8, 0, 0, 0, 8, 0);
        @(posedge clk); #1;
        idle();
        bus.rd_addr = {5'd0, 5'd8};
        #1;
        chk("async_pre_pc", 64'(bus.pend_count), 1);
        chk("async_pre_busy", 64'(bus.rd_busy), 1);
        chk("async_pre_data", 64'(bus.rd_data[31:0]), 32'h55);
        rst_n = 1'b0;
        #1;
        chk("async_pc", 64'(bus.pend_count), 0);
        chk("async_busy", 64'(bus.rd_busy), 0);
        chk("async_data", 64'(bus.rd_data[31:0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;

        // Randomized traffic over a narrow address window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (c % 500 == 499) begin
                idle();
                do_reset();
            end else begin
                @(negedge clk);
                model_check_and_step();
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
